alarm_sequencer: RTL and testbench
==================================

# alarm_sequencer

Alarm controller for the VGA digital clock. Holds the alarm set-point and compares it against the running time once per second. Sequences the ring / snooze / stop life-cycle and drives the 2-bit `count_light` pattern select and `ring` enable consumed by `alarm_clock`. Sits between the timekeeping counters and button debouncers on one side and `alarm_clock` / VGA overlay on the other.

## Interface
- `RING_SECS`, 60: ring duration in 1 Hz ticks before auto-stop; range 1..255.
- `SNOOZE_MIN`, 5: snooze offset in minutes; range 1..59.
- `ALARM_HH_RST`, 7: alarm hour after reset.
- `ALARM_MM_RST`, 0: alarm minute after reset.

- `I_CLK` in 1: system clock. Single clock domain.
- `Rst` in 1: reset, synchronous, active-low.
- `tick_1hz` in 1: one-cycle strobe per second, aligned with the `cur_*` update.
- `cur_hh` in 5: current hour, binary 0..23.
- `cur_mm` in 6: current minute, binary 0..59.
- `cur_ss` in 6: current second, binary 0..59.
- `en_sw` in 1: alarm enable switch, level.
- `set_hh_inc` in 1: one-cycle pulse that increments the alarm hour.
- `set_mm_inc` in 1: one-cycle pulse that increments the alarm minute.
- `stop_btn` in 1: one-cycle pulse that stops ringing.
- `snooze_btn` in 1: one-cycle pulse that requests snooze.
- `alarm_hh` out 5: alarm hour set-point, for display.
- `alarm_mm` out 6: alarm minute set-point, for display.
- `ring` out 1: high while in RINGING.
- `count_light` out 2: light pattern phase.
- `state` out 2: current FSM state, for display.

## Operation
- **Reset values:**
  - state = IDLE (00), `ring` = 0, `count_light` = 0.
  - `alarm_hh` = `ALARM_HH_RST`, `alarm_mm` = `ALARM_MM_RST`.
  - ring counter = 0, snooze target = 0:00.
- **States:** IDLE 00, ARMED 01, RINGING 10, SNOOZE 11.
- **Match condition:** `tick_1hz` & `cur_hh`==target hh & `cur_mm`==target mm & `cur_ss`==0.
  - Target is `alarm_*` in ARMED and the snooze target in SNOOZE.
- **IDLE:** `en_sw`=1 → ARMED.
- **ARMED:** match → RINGING. On entry, load ring counter = `RING_SECS` and clear `count_light` to 0.
- **RINGING:**
  - On each `tick_1hz`: `count_light` += 1 (mod 4) and the ring counter decrements.
  - Tick with counter==1 → ARMED (timeout).
  - `stop_btn` → ARMED.
  - `snooze_btn` → SNOOZE. Snooze target = current time + `SNOOZE_MIN` minutes: minute wraps 59→0 with hour carry, hour wraps 23→0.
- **SNOOZE:** match on the snooze target → RINGING, with the same counter and `count_light` reload as ARMED→RINGING. `stop_btn` → ARMED.
- **Disable:** `en_sw`=0 in any state → IDLE next cycle. `ring` drops and `count_light` returns to 0.
- **Priority within one cycle:** `en_sw`=0 > `stop_btn` > `snooze_btn` > tick events.
- **Set-point adjustment:**
  - `set_hh_inc` wraps 23→0; `set_mm_inc` wraps 59→0, with no hour carry.
  - Accepted only in IDLE and ARMED; ignored in RINGING and SNOOZE.
  - Both pulses in the same cycle both apply.
  - A match in the same cycle as an increment compares against the pre-increment value.
- **Non-RINGING states:** `count_light` holds 0.

## Timing
- All outputs are registered, or decoded directly from registered state.
- Matching tick at cycle N → `state`=RINGING and `ring`=1 at N+1.
- `stop_btn`, `snooze_btn`, `en_sw` fall, or timeout tick at cycle N → `ring`=0 at N+1.
- `count_light` advances at N+1 after each tick in RINGING.
- Ring duration: exactly `RING_SECS` ticks, counting from the entry tick (exclusive) to the timeout tick (inclusive).
- Reset asserted mid-ring: all outputs take their reset values on the next edge.

## Configuration
- **`ALARM_SNOOZE_EN` defined:** SNOOZE state, snooze target registers, and minute adder are present, as specified above.
- **`ALARM_SNOOZE_EN` undefined:**
  - `snooze_btn` is ignored; state 11 is unreachable and, if ever entered, recovers to IDLE next cycle.
  - Snooze registers and adder are not synthesized.
  - The port list is unchanged.

## Structure
- **Package `alarm_pkg`:**
  - State encoding constants IDLE/ARMED/RINGING/SNOOZE.
  - `HH_MAX`=23, `MM_MAX`=59.
  - Field widths 5/6/6.
- **Sub-module `alarm_time_add`:** combinational hh:mm + N-minute adder with carry and wrap. Used for the snooze target; compiled only under `ALARM_SNOOZE_EN`.

## Test plan
- **Set and match:** after reset, `en_sw`=1, time 06:59:59 → tick to 07:00:00 → `ring`=1 next cycle and `count_light` steps 0,1,2,3,0 on successive ticks.
- **Timeout:** with `RING_SECS`=3, ring at 07:00:00 → `ring` drops after the tick at 07:00:03 and the state returns to ARMED.
- **Snooze wrap:** with `SNOOZE_MIN`=5, snooze at 23:58:10 → target 00:03 → `ring`=1 after the tick at 00:03:00. Without `ALARM_SNOOZE_EN`, `snooze_btn` has no effect.
- **Priority:** `stop_btn`, `snooze_btn`, and `en_sw`=0 pulsed in the same cycle while RINGING → state=IDLE, `ring`=0 next cycle.
- **Set-point wrap and lock:** 24 `set_hh_inc` pulses leave `alarm_hh` unchanged. `set_mm_inc` from 59 gives 0 with no hour change. Pulses during RINGING are ignored.
- **Reset mid-ring:** `Rst`=0 for one cycle while RINGING → `alarm_hh`/`alarm_mm` = 7/0, state IDLE, `ring`=0, `count_light`=0.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm sequencer.
// Provides state encoding, time-field widths, wrap limits and the hh:mm payload struct.
package alarm_pkg;

   localparam int unsigned HH_W   = 5;
   localparam int unsigned MM_W   = 6;
   localparam int unsigned SS_W   = 6;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned HH_MAX = 23;
   localparam int unsigned MM_MAX = 59;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ARMED   = 2'b01,
      RINGING = 2'b10,
      SNOOZE  = 2'b11
   } state_e;

   // Hour:minute pair
   typedef struct packed {
      logic [HH_W-1:0] hh;
      logic [MM_W-1:0] mm;
   } hm_t;

endpackage

// File: rtl/alarm_time_add.sv
// Combinational hh:mm + ADD_MIN minute adder; minute wraps 59->0 with hour
// carry, hour wraps 23->0. Only present when ALARM_SNOOZE_EN is defined.
// Ports:
//   t_i     : hh:mm operand
//   sum_c_o : hh:mm result (combinational)
`ifdef ALARM_SNOOZE_EN
module alarm_time_add
   import alarm_pkg::*;
#(
   parameter int unsigned ADD_MIN = 5
) (
   input  hm_t t_i,
   output hm_t sum_c_o
);

   logic [MM_W:0] mm_sum_c;
   logic          carry_c;

   assign mm_sum_c = (MM_W+1)'(t_i.mm) + (MM_W+1)'(ADD_MIN);
   assign carry_c  = mm_sum_c > (MM_W+1)'(MM_MAX);

   always_comb begin
      sum_c_o = t_i;
      if (carry_c) begin
         sum_c_o.mm = MM_W'(mm_sum_c - (MM_W+1)'(MM_MAX + 1));
         sum_c_o.hh = (t_i.hh == HH_W'(HH_MAX)) ? '0 : HH_W'(t_i.hh + HH_W'(1));
      end else begin
         sum_c_o.mm = MM_W'(mm_sum_c);
      end
   end

endmodule
`endif

// File: rtl/alarm_sequencer.sv
// Alarm controller: holds the alarm set-point, compares it with the running
// time on each 1 Hz tick and sequences IDLE/ARMED/RINGING/SNOOZE.
// Optional feature macro: ALARM_SNOOZE_EN (snooze state, target registers, adder).
// Ports:
//   I_CLK, Rst          : clock, synchronous active-low reset
//   tick_1hz            : one-cycle strobe per second, aligned with cur_*
//   cur_hh/cur_mm/cur_ss: current time
//   en_sw               : alarm enable level
//   set_hh_inc/mm_inc   : set-point increment pulses
//   stop_btn/snooze_btn : ring control pulses
//   alarm_hh/alarm_mm   : set-point for display
//   ring, count_light   : ring enable and light pattern phase
//   state               : FSM state for display
module alarm_sequencer
   import alarm_pkg::*;
#(
   parameter int unsigned RING_SECS    = 60,
   parameter int unsigned SNOOZE_MIN   = 5,
   parameter int unsigned ALARM_HH_RST = 7,
   parameter int unsigned ALARM_MM_RST = 0
) (
   input  logic            I_CLK,
   input  logic            Rst,
   input  logic            tick_1hz,
   input  logic [HH_W-1:0] cur_hh,
   input  logic [MM_W-1:0] cur_mm,
   input  logic [SS_W-1:0] cur_ss,
   input  logic            en_sw,
   input  logic            set_hh_inc,
   input  logic            set_mm_inc,
   input  logic            stop_btn,
   input  logic            snooze_btn,
   output logic [HH_W-1:0] alarm_hh,
   output logic [MM_W-1:0] alarm_mm,
   output logic            ring,
   output logic [1:0]      count_light,
   output logic [1:0]      state
);

   state_e           state_q, state_d;
   logic [HH_W-1:0]  alarm_hh_q, alarm_hh_d;
   logic [MM_W-1:0]  alarm_mm_q, alarm_mm_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cl_q, cl_d;

   logic top_of_min_c;
   logic alarm_match_c;
   logic set_ok_c;

   assign top_of_min_c  = tick_1hz && (cur_ss == '0);
   assign alarm_match_c = top_of_min_c && (cur_hh == alarm_hh_q) && (cur_mm == alarm_mm_q);
   assign set_ok_c      = (state_q == IDLE) || (state_q == ARMED);

`ifdef ALARM_SNOOZE_EN
   hm_t  snz_q, snz_d;
   hm_t  cur_hm_c, snz_sum_c;
   logic snz_match_c;

   assign cur_hm_c    = '{hh: cur_hh, mm: cur_mm};
   assign snz_match_c = top_of_min_c && (cur_hh == snz_q.hh) && (cur_mm == snz_q.mm);

   alarm_time_add #(
      .ADD_MIN (SNOOZE_MIN)
   ) u_snz_add (
      .t_i     (cur_hm_c),
      .sum_c_o (snz_sum_c)
   );
`else
   logic [MM_W:0] unused_snooze;
   assign unused_snooze = {snooze_btn, MM_W'(SNOOZE_MIN)};
`endif

   // Next-state, counter, light phase and set-point logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cl_d       = 2'b00;
      alarm_hh_d = alarm_hh_q;
      alarm_mm_d = alarm_mm_q;
`ifdef ALARM_SNOOZE_EN
      snz_d      = snz_q;
`endif

      // Increments only take effect while not ringing or snoozing
      if (set_ok_c && set_hh_inc)
         alarm_hh_d = (alarm_hh_q == HH_W'(HH_MAX)) ? '0 : HH_W'(alarm_hh_q + HH_W'(1));
      if (set_ok_c && set_mm_inc)
         alarm_mm_d = (alarm_mm_q == MM_W'(MM_MAX)) ? '0 : MM_W'(alarm_mm_q + MM_W'(1));

      if (!en_sw) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: state_d = ARMED;
            ARMED: begin
               if (alarm_match_c) begin
                  state_d = RINGING;
                  cnt_d   = CNT_W'(RING_SECS);
               end
            end
            RINGING: begin
               if (stop_btn) begin
                  state_d = ARMED;
               end
`ifdef ALARM_SNOOZE_EN
               else if (snooze_btn) begin
                  state_d = SNOOZE;
                  snz_d   = snz_sum_c;
               end
`endif
               else if (tick_1hz) begin
                  cnt_d = CNT_W'(cnt_q - CNT_W'(1));
                  // Last tick of the ring window returns to ARMED with lights off
                  if (cnt_q == CNT_W'(1))
                     state_d = ARMED;
                  else
                     cl_d = 2'(cl_q + 2'd1);
               end else begin
                  cl_d = cl_q;
               end
            end
            SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
               if (stop_btn) begin
                  state_d = ARMED;
               end else if (snz_match_c) begin
                  state_d = RINGING;
                  cnt_d   = CNT_W'(RING_SECS);
               end
`else
               state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge I_CLK) begin
      if (!Rst) begin
         state_q    <= IDLE;
         alarm_hh_q <= HH_W'(ALARM_HH_RST);
         alarm_mm_q <= MM_W'(ALARM_MM_RST);
         cnt_q      <= '0;
         cl_q       <= 2'b00;
`ifdef ALARM_SNOOZE_EN
         snz_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         alarm_hh_q <= alarm_hh_d;
         alarm_mm_q <= alarm_mm_d;
         cnt_q      <= cnt_d;
         cl_q       <= cl_d;
`ifdef ALARM_SNOOZE_EN
         snz_q      <= snz_d;
`endif
      end
   end

   assign alarm_hh    = alarm_hh_q;
   assign alarm_mm    = alarm_mm_q;
   assign ring        = (state_q == RINGING);
   assign count_light = cl_q;
   assign state       = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: directed scenarios followed by
// randomized stimulus, all compared against a minutes-of-day reference model.
module tb_alarm_sequencer;

   localparam int unsigned RS = 5;
   localparam int unsigned SM = 5;
`ifdef ALARM_SNOOZE_EN
   localparam bit SNZ = 1'b1;
`else
   localparam bit SNZ = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic [4:0] cur_hh = '0;
   logic [5:0] cur_mm = '0;
   logic [5:0] cur_ss = '0;
   logic       en = 1'b0;
   logic       hh_inc = 1'b0;
   logic       mm_inc = 1'b0;
   logic       stop = 1'b0;
   logic       snz = 1'b0;
   logic [4:0] alarm_hh;
   logic [5:0] alarm_mm;
   logic       ring;
   logic [1:0] count_light;
   logic [1:0] state;

   always #5 clk = ~clk;

   alarm_sequencer #(
      .RING_SECS    (RS),
      .SNOOZE_MIN   (SM),
      .ALARM_HH_RST (7),
      .ALARM_MM_RST (0)
   ) dut (
      .I_CLK       (clk),
      .Rst         (rst_n),
      .tick_1hz    (tick),
      .cur_hh      (cur_hh),
      .cur_mm      (cur_mm),
      .cur_ss      (cur_ss),
      .en_sw       (en),
      .set_hh_inc  (hh_inc),
      .set_mm_inc  (mm_inc),
      .stop_btn    (stop),
      .snooze_btn  (snz),
      .alarm_hh    (alarm_hh),
      .alarm_mm    (alarm_mm),
      .ring        (ring),
      .count_light (count_light),
      .state       (state)
   );

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Reference model: state 0..3, set-point, ticks left, light phase, snooze target in minutes of day
   int m_state = 0;
   int m_ahh   = 7;
   int m_amm   = 0;
   int m_left  = 0;
   int m_cl    = 0;
   int m_stgt  = 0;

   function automatic void chk(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   task automatic start_ring();
      m_state = 2;
      m_left  = RS;
      m_cl    = 0;
   endtask

   task automatic model_update();
      int  s;
      int  now_min;
      bit  hit_a, hit_s;
      if (!rst_n) begin
         m_state = 0; m_ahh = 7; m_amm = 0; m_left = 0; m_cl = 0; m_stgt = 0;
         return;
      end
      s       = m_state;
      now_min = int'(cur_hh) * 60 + int'(cur_mm);
      hit_a   = tick && (cur_ss == 0) && (now_min == m_ahh * 60 + m_amm);
      hit_s   = tick && (cur_ss == 0) && (now_min == m_stgt);
      if (!en) begin
         m_state = 0;
         m_cl    = 0;
      end else begin
         case (s)
            0: m_state = 1;
            1: if (hit_a) start_ring();
            2: begin
               if (stop) begin
                  m_state = 1; m_cl = 0;
               end else if (SNZ && snz) begin
                  m_state = 3; m_cl = 0;
                  m_stgt  = (now_min + SM) % 1440;
               end else if (tick) begin
                  m_left--;
                  if (m_left == 0) begin
                     m_state = 1; m_cl = 0;
                  end else begin
                     m_cl = (m_cl + 1) % 4;
                  end
               end
            end
            default: begin
               if (stop) m_state = 1;
               else if (hit_s) start_ring();
            end
         endcase
      end
      if (s <= 1) begin
         if (hh_inc) m_ahh = (m_ahh + 1) % 24;
         if (mm_inc) m_amm = (m_amm + 1) % 60;
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("state", int'(state), m_state);
         chk("ring", int'(ring), (m_state == 2) ? 1 : 0);
         chk("count_light", int'(count_light), m_cl);
         chk("alarm_hh", int'(alarm_hh), m_ahh);
         chk("alarm_mm", int'(alarm_mm), m_amm);
      end
   end

   // One clock: DUT and model both consume the current inputs; pulses then clear
   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      tick = 1'b0; stop = 1'b0; snz = 1'b0; hh_inc = 1'b0; mm_inc = 1'b0; rst_n = 1'b1;
   endtask

   task automatic do_tick(input int hh, input int mm, input int ss);
      cur_hh = 5'(hh); cur_mm = 6'(mm); cur_ss = 6'(ss);
      tick = 1'b1;
      step();
   endtask

   task automatic pulse_hh(input int n);
      repeat (n) begin hh_inc = 1'b1; step(); end
   endtask

   task automatic pulse_mm(input int n);
      repeat (n) begin mm_inc = 1'b1; step(); end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, int'(state), 0);
      chk({tag, "_ring"}, int'(ring), 0);
      chk({tag, "_cl"}, int'(count_light), 0);
      chk({tag, "_ahh"}, int'(alarm_hh), 7);
      chk({tag, "_amm"}, int'(alarm_mm), 0);
   endtask

   initial begin
      int exp_cl[4];
      int sec;
      exp_cl = '{1, 2, 3, 0};

      // Reset
      @(negedge clk);
      rst_n = 1'b0; step();
      rst_n = 1'b0; step();
      chk_en = 1'b1;
      chk_reset_vals("reset");

      // Arm
      en = 1'b1; step();
      chk("arm_state", int'(state), 1);

      // Set and match at 07:00:00, light phase and timeout after RS ticks
      do_tick(6, 59, 58);
      do_tick(6, 59, 59);
      do_tick(7, 0, 0);
      chk("match_ring", int'(ring), 1);
      chk("match_cl0", int'(count_light), 0);
      for (int i = 1; i <= 4; i++) begin
         do_tick(7, 0, i);
         chk("cl_step", int'(count_light), exp_cl[i-1]);
         chk("still_ring", int'(ring), 1);
      end
      do_tick(7, 0, 5);
      chk("timeout_ring", int'(ring), 0);
      chk("timeout_state", int'(state), 1);

      // Set-point wrap
      pulse_hh(24);
      chk("hh_wrap", int'(alarm_hh), 7);
      pulse_mm(59);
      chk("mm_59", int'(alarm_mm), 59);
      pulse_mm(1);
      chk("mm_wrap", int'(alarm_mm), 0);
      chk("mm_wrap_hh", int'(alarm_hh), 7);
      hh_inc = 1'b1; mm_inc = 1'b1; step();
      chk("both_hh", int'(alarm_hh), 8);
      chk("both_mm", int'(alarm_mm), 1);
      pulse_hh(15);
      pulse_mm(57);
      chk("set_2358_hh", int'(alarm_hh), 23);
      chk("set_2358_mm", int'(alarm_mm), 58);

      // Ring at 23:58, locked set-point, snooze across midnight
      do_tick(23, 57, 59);
      do_tick(23, 58, 0);
      chk("ring_2358", int'(ring), 1);
      hh_inc = 1'b1; mm_inc = 1'b1; step();
      chk("lock_hh", int'(alarm_hh), 23);
      chk("lock_mm", int'(alarm_mm), 58);
      do_tick(23, 58, 10);
      snz = 1'b1; step();
      chk("snooze_state", int'(state), SNZ ? 3 : 2);
      chk("snooze_ring", int'(ring), SNZ ? 0 : 1);
      do_tick(0, 2, 59);
      do_tick(0, 3, 0);
      chk("snooze_rering", int'(ring), 1);
      chk("snooze_rering_cl", int'(count_light), SNZ ? 0 : 3);

      // Priority: disable beats stop and snooze
      stop = 1'b1; snz = 1'b1; en = 1'b0; step();
      chk("prio_state", int'(state), 0);
      chk("prio_ring", int'(ring), 0);
      en = 1'b1; step();

      // Reset mid-ring
      do_tick(23, 58, 0);
      chk("ring_again", int'(ring), 1);
      rst_n = 1'b0; step();
      chk_reset_vals("midring_rst");

      // Randomized phase
      sec = 0;
      for (int c = 0; c < 4000; c++) begin
         en     = ($urandom_range(0, 99) != 0);
         rst_n  = ($urandom_range(0, 499) != 0);
         stop   = ($urandom_range(0, 39) == 0);
         snz    = ($urandom_range(0, 29) == 0);
         hh_inc = ($urandom_range(0, 29) == 0);
         mm_inc = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 2) == 0) begin
            tick = 1'b1;
            case ($urandom_range(0, 3))
               0: sec = (m_ahh * 60 + m_amm) * 60;
               1: sec = m_stgt * 60;
               2: sec = int'($urandom_range(0, 86399));
               default: sec = (sec + 1) % 86400;
            endcase
            cur_hh = 5'(sec / 3600);
            cur_mm = 6'((sec / 60) % 60);
            cur_ss = 6'(sec % 60);
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
